rgb_gray_combiner: RTL and testbench

- Downstream consumer of the per-channel weighted outputs produced by the Rmulti/Gmulti/Bmulti stage.
- Accepts an interleaved byte stream R,G,B,R,G,B,... of already-weighted channel values over a valid/ready handshake.
- Sums each triplet into one grayscale pixel, with optional saturation, and presents it on a valid/ready output.
- Tracks pixel count, end of frame and framing errors, so the hardware path replaces the three separate per-channel output files.

---
 rtl/gray_pkg.sv | 23 ++
 rtl/rgb_gray_combiner.sv | 128 ++++++++++++
 tb/tb_rgb_gray_combiner.sv | 246 ++++++++++++++++++++++++
 3 files changed

// File: rtl/gray_pkg.sv
// Shared definitions for the RGB-to-gray path: FSM states, channel order and the
// luma weights that the upstream multiplier stage applies to each channel.
package gray_pkg;

    localparam int DATA_W_DEF = 8;

    typedef enum logic [1:0] {
        S_R   = 2'd0,
        S_G   = 2'd1,
        S_B   = 2'd2,
        S_OUT = 2'd3
    } state_t;

    localparam logic [1:0] CH_R = 2'd0;
    localparam logic [1:0] CH_G = 2'd1;
    localparam logic [1:0] CH_B = 2'd2;

    // Weights are fractions of 256: gray = (77 R + 150 G + 29 B) / 256
    localparam logic [7:0] W_R = 8'd77;
    localparam logic [7:0] W_G = 8'd150;
    localparam logic [7:0] W_B = 8'd29;

endpackage

// File: rtl/rgb_gray_combiner.sv
// Sums interleaved R,G,B weighted bytes into one gray pixel with optional clamp,
// and tracks pixel count, frame end and framing errors.
module rgb_gray_combiner
    import gray_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int CNT_W  = 16,
    parameter bit SAT_EN = 1'b1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_last,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_gray,
    output logic              out_sat,
    output logic              out_last,
    output logic [CNT_W-1:0]  pix_count,
    output logic              frame_done,
    output logic              framing_err
);

    localparam int ACC_W = DATA_W + 2;
    localparam logic [ACC_W-1:0] MAX_ACC = {2'b00, {DATA_W{1'b1}}};
    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    state_t             state_r;
    state_t             next_state_s;
    logic [ACC_W-1:0]   acc_r;
    logic [ACC_W-1:0]   sum_s;
    logic               accept_s;
    logic               xfer_s;
    logic               in_ready_r;
    logic               out_valid_r;
    logic [DATA_W-1:0]  out_gray_r;
    logic               out_sat_r;
    logic               out_last_r;
    logic [CNT_W-1:0]   pix_count_r;
    logic               frame_done_r;
    logic               framing_err_r;

    function automatic logic [DATA_W-1:0] clamp_sum(input logic [ACC_W-1:0] s);
        if (SAT_EN && (s > MAX_ACC)) begin
            return MAX_ACC[DATA_W-1:0];
        end else begin
            return s[DATA_W-1:0];
        end
    endfunction

    assign in_ready    = in_ready_r;
    assign out_valid   = out_valid_r;
    assign out_gray    = out_gray_r;
    assign out_sat     = out_sat_r;
    assign out_last    = out_last_r;
    assign pix_count   = pix_count_r;
    assign frame_done  = frame_done_r;
    assign framing_err = framing_err_r;

    // Handshake decode, running sum and next-state selection
    always_comb begin
        accept_s     = in_valid & in_ready_r;
        xfer_s       = out_valid_r & out_ready;
        sum_s        = acc_r + {2'b00, in_data};
        next_state_s = state_r;
        case (state_r)
            S_R:   if (accept_s) next_state_s = S_G;   else next_state_s = S_R;
            S_G:   if (accept_s) next_state_s = S_B;   else next_state_s = S_G;
            S_B:   if (accept_s) next_state_s = S_OUT; else next_state_s = S_B;
            S_OUT: if (xfer_s)   next_state_s = S_R;   else next_state_s = S_OUT;
            default: next_state_s = S_R;
        endcase
    end

    // State, accumulator and registered outputs; handshake flags follow the next state
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r       <= S_R;
            acc_r         <= {ACC_W{1'b0}};
            in_ready_r    <= 1'b1;
            out_valid_r   <= 1'b0;
            out_gray_r    <= {DATA_W{1'b0}};
            out_sat_r     <= 1'b0;
            out_last_r    <= 1'b0;
            pix_count_r   <= {CNT_W{1'b0}};
            frame_done_r  <= 1'b0;
            framing_err_r <= 1'b0;
        end else begin
            state_r      <= next_state_s;
            in_ready_r   <= (next_state_s != S_OUT);
            out_valid_r  <= (next_state_s == S_OUT);
            frame_done_r <= 1'b0;
            case (state_r)
                S_R: begin
                    if (accept_s) begin
                        acc_r <= {2'b00, in_data};
                        if (in_last) framing_err_r <= 1'b1;
                    end
                end
                S_G: begin
                    if (accept_s) begin
                        acc_r <= sum_s;
                        if (in_last) framing_err_r <= 1'b1;
                    end
                end
                S_B: begin
                    if (accept_s) begin
                        out_gray_r <= clamp_sum(sum_s);
                        out_sat_r  <= (sum_s > MAX_ACC);
                        out_last_r <= in_last;
                    end
                end
                S_OUT: begin
                    if (xfer_s) begin
                        pix_count_r  <= pix_count_r + CNT_ONE;
                        frame_done_r <= out_last_r;
                    end
                end
                default: begin
                    acc_r <= {ACC_W{1'b0}};
                end
            endcase
        end
    end

endmodule

// File: tb/tb_rgb_gray_combiner.sv
// Scoreboard bench: a byte-level model pushes expected pixels as bytes are accepted;
// a negedge monitor pops and compares them as pixels transfer out.
module tb_rgb_gray_combiner;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic [7:0]  in_data = 8'd0;
    logic        in_last = 1'b0;
    logic        out_ready = 1'b1;

    logic        in_ready, out_valid, out_sat, out_last, frame_done, framing_err;
    logic [7:0]  out_gray;
    logic [15:0] pix_count;
    logic        w_in_ready, w_out_valid, w_out_sat, w_out_last, w_frame_done, w_framing_err;
    logic [7:0]  w_out_gray;
    logic [15:0] w_pix_count;

    always #5 clk = ~clk;

    rgb_gray_combiner #(.DATA_W(8), .CNT_W(16), .SAT_EN(1'b1)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .in_data(in_data), .in_last(in_last), .out_valid(out_valid),
        .out_ready(out_ready), .out_gray(out_gray), .out_sat(out_sat),
        .out_last(out_last), .pix_count(pix_count), .frame_done(frame_done),
        .framing_err(framing_err)
    );

    rgb_gray_combiner #(.DATA_W(8), .CNT_W(16), .SAT_EN(1'b0)) dut_wrap (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(w_in_ready),
        .in_data(in_data), .in_last(in_last), .out_valid(w_out_valid),
        .out_ready(out_ready), .out_gray(w_out_gray), .out_sat(w_out_sat),
        .out_last(w_out_last), .pix_count(w_pix_count), .frame_done(w_frame_done),
        .framing_err(w_framing_err)
    );

    typedef struct {
        logic [7:0] gray;
        logic [7:0] wrap;
        logic       sat;
        logic       last;
    } exp_t;

    exp_t        sb[$];
    int          checks = 0;
    int          failures = 0;
    int          m_idx = 0;
    int          m_acc = 0;
    int          exp_pix = 0;
    logic        fd_exp = 1'b0;
    logic        ferr_exp = 1'b0;
    logic        started = 1'b0;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0d expected=%0d", tag, act, exp);
        end
    endtask

    // Called just after a rising edge; returns just after the edge that accepted the byte
    task automatic send_byte(input logic [7:0] d, input logic l);
        logic ok;
        int   sum;
        exp_t e;
        ok = 1'b0;
        in_valid = 1'b1;
        in_data  = d;
        in_last  = l;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (in_ready) begin
                ok = 1'b1;
                break;
            end
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_last  = 1'b0;
        if (!ok) begin
            chk("accept_timeout", 32'd0, 32'd1);
        end else begin
            if (m_idx == 0) begin
                m_acc = int'(d);
                if (l) ferr_exp = 1'b1;
            end else if (m_idx == 1) begin
                m_acc = m_acc + int'(d);
                if (l) ferr_exp = 1'b1;
            end else begin
                sum    = m_acc + int'(d);
                e.gray = (sum > 255) ? 8'd255 : sum[7:0];
                e.wrap = sum[7:0];
                e.sat  = (sum > 255);
                e.last = l;
                sb.push_back(e);
            end
            m_idx = (m_idx + 1) % 3;
        end
    endtask

    task automatic pulse_rst();
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        m_idx    = 0;
        m_acc    = 0;
        ferr_exp = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Output monitor: pops the scoreboard on each transfer and tracks count/frame pulse
    always @(negedge clk) begin
        exp_t e;
        if (started) begin
            chk("pix_count", 32'(pix_count), 32'(exp_pix));
            chk("frame_done", 32'(frame_done), 32'(fd_exp));
        end
        if (rst) begin
            exp_pix = 0;
            fd_exp  = 1'b0;
            sb.delete();
        end else begin
            fd_exp = 1'b0;
            if (out_valid && out_ready) begin
                if (sb.size() == 0) begin
                    chk("unexpected_pixel", 32'd1, 32'd0);
                end else begin
                    e = sb.pop_front();
                    chk("out_gray", 32'(out_gray), 32'(e.gray));
                    chk("out_sat", 32'(out_sat), 32'(e.sat));
                    chk("out_last", 32'(out_last), 32'(e.last));
                    chk("wrap_valid", 32'(w_out_valid), 32'd1);
                    chk("wrap_gray", 32'(w_out_gray), 32'(e.wrap));
                    chk("wrap_sat", 32'(w_out_sat), 32'(e.sat));
                    exp_pix = (exp_pix + 1) % 65536;
                    fd_exp  = e.last;
                end
            end
        end
    end

    initial begin
        idle(2);
        rst = 1'b0;
        @(negedge clk);
        started = 1'b1;
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_out_gray", 32'(out_gray), 32'd0);
        chk("rst_out_sat", 32'(out_sat), 32'd0);
        chk("rst_out_last", 32'(out_last), 32'd0);
        chk("rst_framing_err", 32'(framing_err), 32'd0);
        @(posedge clk);
        #1;

        // basic pixel and one-cycle output latency
        send_byte(8'd60, 1'b0);
        send_byte(8'd87, 1'b0);
        chk("pre_valid", 32'(out_valid), 32'd0);
        send_byte(8'd11, 1'b0);
        chk("lat_valid", 32'(out_valid), 32'd1);
        chk("lat_in_ready", 32'(in_ready), 32'd0);
        idle(2);
        chk("basic_count", 32'(pix_count), 32'd1);

        // saturation (clamped and wrapped instances)
        send_byte(8'd200, 1'b0);
        send_byte(8'd50, 1'b0);
        send_byte(8'd10, 1'b0);
        idle(2);

        // backpressure: output held, extra input not consumed
        out_ready = 1'b0;
        send_byte(8'd10, 1'b0);
        send_byte(8'd20, 1'b0);
        send_byte(8'd30, 1'b0);
        in_valid = 1'b1;
        in_data  = 8'd99;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("bp_valid", 32'(out_valid), 32'd1);
            chk("bp_gray", 32'(out_gray), 32'd60);
            chk("bp_in_ready", 32'(in_ready), 32'd0);
        end
        @(posedge clk);
        #1;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        @(negedge clk);
        chk("bp_release_ready", 32'(in_ready), 32'd1);
        chk("bp_release_valid", 32'(out_valid), 32'd0);
        chk("bp_count", 32'(pix_count), 32'd3);
        @(posedge clk);
        #1;

        // frame end over three pixels
        pulse_rst();
        for (int p = 0; p < 3; p++) begin
            send_byte(8'(p * 3 + 1), 1'b0);
            send_byte(8'(p * 3 + 2), 1'b0);
            send_byte(8'(p * 3 + 3), p == 2);
        end
        idle(3);
        chk("frame_count", 32'(pix_count), 32'd3);
        chk("frame_err_clear", 32'(framing_err), 32'(ferr_exp));

        // framing error on the G byte, sticky across later pixels
        send_byte(8'd1, 1'b0);
        send_byte(8'd2, 1'b1);
        send_byte(8'd3, 1'b0);
        idle(2);
        chk("ferr_set", 32'(framing_err), 32'(ferr_exp));
        send_byte(8'd4, 1'b0);
        send_byte(8'd5, 1'b0);
        send_byte(8'd6, 1'b0);
        idle(2);
        chk("ferr_sticky", 32'(framing_err), 32'(ferr_exp));

        // reset mid-pixel discards partial triplet
        send_byte(8'd5, 1'b0);
        send_byte(8'd6, 1'b0);
        pulse_rst();
        send_byte(8'd1, 1'b0);
        send_byte(8'd2, 1'b0);
        send_byte(8'd3, 1'b0);
        idle(3);
        chk("midrst_count", 32'(pix_count), 32'd1);
        chk("midrst_ferr", 32'(framing_err), 32'd0);
        chk("sb_drained", 32'(sb.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
